bubble_sort_engine: RTL and testbench
=====================================

# bubble_sort_engine

Parametrised serial sorting engine built on the compare-and-swap primitive of the bubble serial sort design. It accepts a frame of N signed words over a valid/ready input stream, sorts them in place with odd-even transposition passes, and streams the sorted frame out with valid/ready and a last-word flag. Sort direction is selectable per frame.

## Interface
- `W`, 8: data word width, in bits, two's complement signed.
- `N`, 8: words per frame; legal range is N ≥ 2.
- `clk` input, 1 bit: clock; all logic is rising-edge.
- `rst_n` input, 1 bit: asynchronous reset, active low.
- `in_valid` input, 1 bit: the input word is valid.
- `in_ready` output, 1 bit: the engine can accept an input word.
- `in_data` input, W bits, signed: input word.
- `descend` input, 1 bit: 0 sorts ascending, 1 sorts descending. It is sampled together with the first word of each frame.
- `out_valid` output, 1 bit: the output word is valid.
- `out_ready` input, 1 bit: the downstream block accepts the output word.
- `out_data` output, W bits, signed: sorted output word.
- `out_last` output, 1 bit: marks the final word of the frame.
- `busy` output, 1 bit: high in SORT and DRAIN.

## Operation
- States are LOAD, SORT and DRAIN. Reset forces the engine to LOAD, clears the buffer, and clears the word index, phase counter and mode register.
- **LOAD:**
  - `in_ready`=1. Each `in_valid`&&`in_ready` writes `in_data` to `buf[idx]` and increments idx.
  - The handshake at idx 0 latches `descend` into the frame mode register.
  - The handshake at idx N-1 clears idx and moves the engine to SORT.
- **SORT:** one transposition phase per cycle.
  - Even phase (phase counter bit 0 = 0) compares pairs (0,1),(2,3),…
  - Odd phase compares pairs (1,2),(3,4),…
  - Each pair goes through one compare-swap. Ascending swaps when `buf[i]` > `buf[i+1]` as a signed comparison. Descending swaps when `buf[i]` < `buf[i+1]`.
  - Equal values never swap, so the sort is stable.
  - After exactly N phases the engine moves to DRAIN. Without early exit this is the only way out of SORT.
- **DRAIN:**
  - `out_valid`=1 and `out_data`=`buf[idx]`.
  - `out_last`=1 when idx=N-1.
  - idx advances on `out_valid`&&`out_ready`.
  - The handshake on the last word clears idx and returns the engine to LOAD.
- `in_ready`=0 outside LOAD. `out_valid`=0 outside DRAIN.
- Comparisons are full W-bit signed. Examples: -128 < 127, and -1 < 0. There is no widening and no saturation.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_data`=0, `out_last`=0, `busy`=0.
- If the last input handshake is in cycle t:
  - SORT occupies cycles t+1 to t+N.
  - `out_valid` rises in cycle t+N+1.
- Each output word costs a minimum of 1 cycle, so a full frame drains in N cycles without backpressure.
- While `out_valid`=1 and `out_ready`=0, `out_data` and `out_last` hold stable.
- `out_ready` is ignored outside DRAIN. `in_valid` is ignored outside LOAD, and no word is lost or buffered.
- The return from DRAIN to LOAD takes no bubble: `in_ready`=1 in the cycle after the last output handshake.
- `rst_n` asserted in any state takes effect immediately. The engine returns to LOAD, and the partial frame and its mode are discarded.
- `descend` changing mid-frame has no effect until the next frame's first word.

## Configuration
- `SORT_EARLY_EXIT_EN` defined:
  - SORT keeps a no-swap flag for each phase.
  - When two consecutive phases both perform zero swaps, the frame is sorted. The engine then moves to DRAIN after the second of those phases, or after phase N if that comes first.
  - Minimum SORT duration is 2 cycles, giving a pre-sorted frame latency of t+3.
- `SORT_EARLY_EXIT_EN` undefined: SORT is always exactly N cycles.

## Structure
- Package `sort_pkg` holds:
  - the state enum (LOAD, SORT, DRAIN);
  - the index-width constant, $clog2(N) with a minimum of 1;
  - the phase-counter width.
- Sub-module `cmp_swap` is combinational and is instantiated once per pair in a generate loop. It is parametrised by W and has these ports:
  - inputs: a, b and descend;
  - outputs: lo, hi and swapped.
- The top level contains the FSM, the buffer, the counters and the stream logic.

## Test plan
All scenarios use W=8, N=4.
- Ascending basic: load -5, 4, 127, -128 with `descend`=0 → outputs -128, -5, 4, 127, with `out_last` on 127. `out_valid` rises exactly 5 cycles after the last input handshake.
- Descending with duplicates: load 3, -1, 3, 0 with `descend`=1 → outputs 3, 3, 0, -1. `descend` is toggled after the first word and has no effect.
- Backpressure: hold `out_ready`=0 for 3 cycles on the second word → `out_data` stays at that word and `out_last` stays 0, with no skip and no repeat. `in_ready` stays 0 throughout.
- Early exit (macro defined): load 1, 2, 3, 4 ascending → `out_valid` rises 3 cycles after the last input. With the macro undefined it rises after 5 cycles, and the output is identical.
- Reset mid-drain: assert `rst_n`=0 after the second output handshake → the next cycle shows `out_valid`=0, `in_ready`=1 and `busy`=0. A fresh frame 0, 0, 0, -1 then sorts to -1, 0, 0, 0.
- Back-to-back frames: input is held valid across the DRAIN→LOAD boundary → the first word of the next frame is accepted in the cycle after the previous `out_last` handshake.

Source files
------------

// File: rtl/sort_pkg.sv
// Shared types and width helpers for the odd-even transposition sorting engine.
package sort_pkg;

  localparam int unsigned SORT_W_DEF = 32'd8;
  localparam int unsigned SORT_N_DEF = 32'd8;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Word index width: $clog2(n), never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    if (n <= 32'd2) begin
      return 32'd1;
    end else begin
      return $clog2(n);
    end
  endfunction

  // Phase counter only needs to reach n-1, so it shares the index width.
  function automatic int unsigned phase_width(input int unsigned n);
    return idx_width(n);
  endfunction

endpackage

// File: rtl/cmp_swap.sv
// Combinational compare-and-swap of one adjacent pair; ties never swap, which keeps the sort stable.
module cmp_swap #(
  parameter int W = 8
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  input  logic                descend,
  output logic signed [W-1:0] lo,
  output logic signed [W-1:0] hi,
  output logic                swapped
);

  // Order the pair for the requested direction.
  always_comb begin
    swapped = descend ? (a < b) : (a > b);
    if (swapped) begin
      lo = b;
      hi = a;
    end else begin
      lo = a;
      hi = b;
    end
  end

endmodule

// File: rtl/bubble_sort_engine.sv
// Serial frame sorter: LOAD N words, N odd-even transposition phases, DRAIN with last flag.
// Optional SORT_EARLY_EXIT_EN leaves SORT after two consecutive swap-free phases.
module bubble_sort_engine
  import sort_pkg::*;
#(
  parameter int W = SORT_W_DEF,
  parameter int N = SORT_N_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] in_data,
  input  logic                descend,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] out_data,
  output logic                out_last,
  output logic                busy
);

  localparam int IW = idx_width(N);
  localparam int PW = phase_width(N);
  localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);
  localparam logic [PW-1:0] PH_LAST  = PW'(N - 1);
  localparam logic [PW-1:0] PH_ONE   = PW'(1);

  state_e              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [PW-1:0]       phase_q, phase_d;
  logic                mode_q, mode_d;
  logic signed [W-1:0] mem_q [N];
  logic signed [W-1:0] mem_d [N];

  logic signed [W-1:0] lo_s [N-1];
  logic signed [W-1:0] hi_s [N-1];
  logic [N-2:0]        sw_s;
  logic                any_swap_s;
  logic                sort_done_s;
  logic                drain_s;

  for (genvar p = 0; p < N - 1; p++) begin : g_pair
    cmp_swap #(.W(W)) u_cmp_swap (
      .a       (mem_q[p]),
      .b       (mem_q[p+1]),
      .descend (mode_q),
      .lo      (lo_s[p]),
      .hi      (hi_s[p]),
      .swapped (sw_s[p])
    );
  end

  // Buffer next state: load writes one slot, a sort phase rewrites the pairs of its parity.
  always_comb begin
    mem_d      = mem_q;
    any_swap_s = 1'b0;
    case (state_q)
      LOAD: begin
        if (in_valid) begin
          mem_d[idx_q] = in_data;
        end else begin
          mem_d[idx_q] = mem_q[idx_q];
        end
      end
      SORT: begin
        for (int p = 0; p < N - 1; p++) begin
          if (p[0] == phase_q[0]) begin
            mem_d[p]   = lo_s[p];
            mem_d[p+1] = hi_s[p];
            any_swap_s = any_swap_s | sw_s[p];
          end else begin
            any_swap_s = any_swap_s;
          end
        end
      end
      default: begin
        mem_d = mem_q;
      end
    endcase
  end

`ifdef SORT_EARLY_EXIT_EN
  logic noswap_q, noswap_d;

  // Two clean phases in a row (one of each parity) mean every adjacent pair is ordered.
  assign sort_done_s = (phase_q == PH_LAST) || (noswap_q && !any_swap_s);

  // Remember whether the previous phase was swap-free; cleared outside SORT.
  always_comb begin
    if (state_q == SORT) begin
      noswap_d = !any_swap_s;
    end else begin
      noswap_d = 1'b0;
    end
  end

  // No-swap history register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      noswap_q <= 1'b0;
    end else begin
      noswap_q <= noswap_d;
    end
  end
`else
  logic unused_swap_s;
  assign unused_swap_s = any_swap_s;
  assign sort_done_s   = (phase_q == PH_LAST);
`endif

  // FSM next state plus index, phase and frame-mode updates.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    phase_d = phase_q;
    mode_d  = mode_q;
    case (state_q)
      LOAD: begin
        if (in_valid) begin
          if (idx_q == '0) begin
            mode_d = descend;
          end else begin
            mode_d = mode_q;
          end
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            phase_d = '0;
            state_d = SORT;
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end else begin
          idx_d = idx_q;
        end
      end
      SORT: begin
        if (sort_done_s) begin
          phase_d = '0;
          state_d = DRAIN;
        end else begin
          phase_d = phase_q + PH_ONE;
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = LOAD;
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end else begin
          idx_d = idx_q;
        end
      end
      default: begin
        state_d = LOAD;
      end
    endcase
  end

  // State, counters, mode and buffer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD;
      idx_q   <= '0;
      phase_q <= '0;
      mode_q  <= 1'b0;
      for (int i = 0; i < N; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      phase_q <= phase_d;
      mode_q  <= mode_d;
      mem_q   <= mem_d;
    end
  end

  assign drain_s   = (state_q == DRAIN);
  assign in_ready  = (state_q == LOAD);
  assign busy      = (state_q != LOAD);
  assign out_valid = drain_s;
  assign out_data  = drain_s ? mem_q[idx_q] : '0;
  assign out_last  = drain_s && (idx_q == IDX_LAST);

endmodule

// File: tb/tb_bubble_sort_engine.sv
// Self-checking bench for bubble_sort_engine (W=8, N=4): table frames, random frames, corner sequences.
module tb_bubble_sort_engine;

  localparam int W = 8;
  localparam int N = 4;
`ifdef SORT_EARLY_EXIT_EN
  localparam int PRESORT_LAT = 3;
`else
  localparam int PRESORT_LAT = 5;
`endif

  logic                clk = 1'b0;
  logic                rst_n;
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] in_data;
  logic                descend;
  logic                out_valid;
  logic                out_ready;
  logic signed [W-1:0] out_data;
  logic                out_last;
  logic                busy;

  bubble_sort_engine #(.W(W), .N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .descend   (descend),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {int d; logic last;} exp_t;
  typedef struct {int din[4]; logic desc; int dexp[4]; int lat;} vec_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   last_in_cyc = 0;
  int   last_out_cyc = 0;
  int   expect_lat = -1;
  logic prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Output monitor: latency of out_valid rise, then scoreboard pop on each handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid && !prev_valid && expect_lat >= 0) begin
      chk("out_valid_latency", cyc - last_in_cyc, expect_lat);
      expect_lat = -1;
    end
    prev_valid = out_valid;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_output: got %0d, expected no word", out_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_data", out_data, e.d);
        chk("out_last", out_last, e.last);
        if (out_last) last_out_cyc = cyc;
      end
    end
  end

  task automatic push_exp(input int e[4], input int cnt);
    for (int k = 0; k < cnt; k++) sb.push_back('{e[k], (k == 3)});
  endtask

  task automatic push_word(input int d, input logic desc, output int t);
    int   n;
    logic ok;
    in_valid = 1'b1;
    in_data  = 8'(d);
    descend  = desc;
    ok = 1'b0;
    n  = 0;
    t  = 0;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = in_ready;
      t  = cyc;
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL in_accept_timeout: got no handshake, expected one within 200 cycles");
    end
  endtask

  // descend is flipped after the first word; only the first-word value may matter.
  task automatic send_frame(input int w[4], input logic desc, input logic hold, input int lat,
                            output int t_first);
    int t;
    t_first = 0;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) expect_lat = lat;
      push_word(w[k], (k == 0) ? desc : ~desc, t);
      if (k == 0) t_first = t;
      if (k == 3) last_in_cyc = t;
    end
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
    #1;
    chk("frame_drained", sb.size(), 0);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("out_valid_seen", out_valid, 1);
  endtask

  task automatic model_sort(input int w[4], input logic desc, output int r[4]);
    int key, j;
    r = w;
    for (int i = 1; i < 4; i++) begin
      key = r[i];
      j = i;
      while (j > 0) begin
        if (desc ? (r[j-1] < key) : (r[j-1] > key)) begin
          r[j] = r[j-1];
          j--;
        end else break;
      end
      r[j] = key;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vec[5];
    int   w[4], e[4], t, tb_first;

    vec[0].din = '{-5, 4, 127, -128}; vec[0].desc = 1'b0; vec[0].dexp = '{-128, -5, 4, 127}; vec[0].lat = 5;
    vec[1].din = '{3, -1, 3, 0};      vec[1].desc = 1'b1; vec[1].dexp = '{3, 3, 0, -1};      vec[1].lat = 5;
    vec[2].din = '{1, 2, 3, 4};       vec[2].desc = 1'b0; vec[2].dexp = '{1, 2, 3, 4};       vec[2].lat = PRESORT_LAT;
    vec[3].din = '{4, 3, 2, 1};       vec[3].desc = 1'b1; vec[3].dexp = '{4, 3, 2, 1};       vec[3].lat = PRESORT_LAT;
    vec[4].din = '{-1, 0, -128, 127}; vec[4].desc = 1'b0; vec[4].dexp = '{-128, -1, 0, 127}; vec[4].lat = -1;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; descend = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      push_exp(vec[i].dexp, 4);
      send_frame(vec[i].din, vec[i].desc, 1'b0, vec[i].lat, t);
      wait_empty();
    end

    for (int f = 0; f < 4; f++) begin
      for (int k = 0; k < 4; k++)
        w[k] = f[0] ? (int'($urandom_range(0, 3)) - 2) : (int'($urandom_range(0, 255)) - 128);
      model_sort(w, f[1], e);
      push_exp(e, 4);
      send_frame(w, f[1], 1'b0, -1, t);
      wait_empty();
    end

    // Backpressure on the second output word.
    out_ready = 1'b0;
    w = '{10, -20, 30, -40};
    push_exp('{30, 10, -20, -40}, 4);
    send_frame(w, 1'b1, 1'b0, 5, t);
    wait_valid();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_hold_data", out_data, 10);
      chk("bp_hold_last", out_last, 0);
      chk("bp_in_ready", in_ready, 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_empty();

    // Reset after the second output handshake, then a fresh frame.
    out_ready = 1'b0;
    w = '{7, -3, 100, -50};
    push_exp('{-50, -3, 7, 100}, 2);
    send_frame(w, 1'b0, 1'b0, -1, t);
    wait_valid();
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_sb_empty", sb.size(), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    push_exp('{-1, 0, 0, 0}, 4);
    send_frame('{0, 0, 0, -1}, 1'b0, 1'b0, 5, t);
    wait_empty();

    // Back-to-back frames with in_valid held across the DRAIN->LOAD boundary.
    push_exp('{-9, 0, 1, 9}, 4);
    send_frame('{9, -9, 0, 1}, 1'b0, 1'b1, 5, t);
    push_exp('{5, 5, -2, -7}, 4);
    send_frame('{-2, 5, -7, 5}, 1'b1, 1'b0, 5, tb_first);
    chk("b2b_first_accept_cycle", tb_first, last_out_cyc + 1);
    wait_empty();

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
